// File: rtl/input_conditioner_if.sv
// ---------------------------------------------------------------------------
// input_conditioner_if
//
// Groups the board-side inputs and the conditioned outputs of
// input_conditioner into one bundle. The clock and reset stay as plain
// ports on the module.
//
//   sw_in       raw switches (asynchronous)
//   key_in_L    raw pushbuttons (asynchronous, 0 = pressed)
//   sw_sync     synchronised switch levels
//   key_down    debounced key level (1 = pressed)
//   key_press   one-cycle pulse per debounced press (or auto-repeat)
//   key_release one-cycle pulse per debounced release
//   any_press   OR of all key_press bits
//
// The master modport is the board side that drives the raw inputs.
// The slave modport is the conditioner itself.
// ---------------------------------------------------------------------------
interface input_conditioner_if #(
  parameter int NUM_SW  = 18,
  parameter int NUM_KEY = 4
);
  logic [NUM_SW-1:0]  sw_in;
  logic [NUM_KEY-1:0] key_in_L;
  logic [NUM_SW-1:0]  sw_sync;
  logic [NUM_KEY-1:0] key_down;
  logic [NUM_KEY-1:0] key_press;
  logic [NUM_KEY-1:0] key_release;
  logic               any_press;

  modport master (
    output sw_in, key_in_L,
    input  sw_sync, key_down, key_press, key_release, any_press
  );

  modport slave (
    input  sw_in, key_in_L,
    output sw_sync, key_down, key_press, key_release, any_press
  );
endinterface

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// This block sits directly behind the board pins. It turns raw switches and
// pushbuttons into clean, clock-synchronous signals.
//   - Switches: a SYNC_STAGES-deep flop chain and nothing else.
//   - Keys: a SYNC_STAGES-deep flop chain, followed by inversion and a
//     per-key debounce FSM. The FSM produces registered press and release
//     pulses.
//
// Ports
//   CLOCK_50  the only clock
//   reset_L   asynchronous, active-low reset
//   bus       input_conditioner_if.slave (sw_in, key_in_L in;
//             sw_sync, key_down, key_press, key_release, any_press out)
//
// Optional feature
//   Define INPUT_COND_AUTOREPEAT_EN to add auto-repeat. A held key then
//   fires an extra key_press REPEAT_DELAY cycles after the initial press,
//   and another one every REPEAT_PERIOD cycles after that.
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int NUM_SW          = 18,
  parameter int NUM_KEY         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_L,
  input_conditioner_if.slave    bus
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_params
    $error("input_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_e;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int               RPT_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
  localparam int               RPT_W     = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER   = RPT_W'(REPEAT_PERIOD);
`endif

  // Synchroniser chains. Index 0 is the stage that samples the pin.
  logic [SYNC_STAGES-1:0][NUM_SW-1:0]  sw_chain_q;
  logic [SYNC_STAGES-1:0][NUM_KEY-1:0] key_chain_q;

  // NOTE: sequential state is only ever updated with non-blocking (<=)
  // assignments, so every flop samples the pre-edge values of its neighbours.
  // Key chains reset to 1 because a released button reads as 1 on the pin.
  always_ff @(posedge CLOCK_50 or negedge reset_L) begin
    if (!reset_L) begin
      sw_chain_q  <= '0;
      key_chain_q <= '1;
    end else begin
      sw_chain_q  <= {sw_chain_q[SYNC_STAGES-2:0], bus.sw_in};
      key_chain_q <= {key_chain_q[SYNC_STAGES-2:0], bus.key_in_L};
    end
  end

  assign bus.sw_sync = sw_chain_q[SYNC_STAGES-1];

  logic [NUM_KEY-1:0] down_vec;
  logic [NUM_KEY-1:0] press_vec;
  logic [NUM_KEY-1:0] release_vec;

  for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             down_q, press_q, release_q;
    logic             down_d, press_d, release_d;
    logic             sample;
    logic             rpt_fire;

    // Active-high sampled level (1 = pressed).
    assign sample = ~key_chain_q[SYNC_STAGES-1][k];

    // NOTE: every signal written here gets a default first. Paths that do
    // not assign a signal would otherwise infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        RELEASED: begin
          if (sample) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = PRESSED;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!sample) begin
            state_d = RELEASED;   // glitch: restart from the stable state
            cnt_d   = '0;
          end else if (cnt_q >= DEB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sample) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = RELEASED;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (sample) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q >= DEB_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    // The repeat counter only runs while the key stays in PRESSED.
    // rpt_again_q selects the period once the first repeat has fired.
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_inc, rpt_target;
    logic             rpt_again_q, rpt_again_d;

    always_comb begin
      rpt_inc     = rpt_cnt_q + RPT_W'(1);
      rpt_target  = rpt_again_q ? RPT_PER : RPT_DELAY;
      rpt_fire    = 1'b0;
      rpt_cnt_d   = '0;
      rpt_again_d = 1'b0;
      if (state_q == PRESSED && state_d == PRESSED) begin
        if (rpt_inc >= rpt_target) begin
          rpt_fire    = 1'b1;
          rpt_again_d = 1'b1;
        end else begin
          rpt_cnt_d   = rpt_inc;
          rpt_again_d = rpt_again_q;
        end
      end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
      if (!reset_L) begin
        rpt_cnt_q   <= '0;
        rpt_again_q <= 1'b0;
      end else begin
        rpt_cnt_q   <= rpt_cnt_d;
        rpt_again_q <= rpt_again_d;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // The pulses are computed from the next state. They are therefore high
    // in the same cycle as the new key_down level.
    assign down_d    = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    assign press_d   = (down_d & ~down_q) | rpt_fire;
    assign release_d = ~down_d & down_q;

    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
      if (!reset_L) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        down_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        down_q    <= down_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign down_vec[k]    = down_q;
    assign press_vec[k]   = press_q;
    assign release_vec[k] = release_q;
  end

  assign bus.key_down    = down_vec;
  assign bus.key_press   = press_vec;
  assign bus.key_release = release_vec;
  assign bus.any_press   = |press_vec;

endmodule
